// File: rtl/snake_pkg.sv
// Shared constants for the snake movement scheduler: headings, PS/2 make
// codes, game state encoding and the heading-reversal helper.
package snake_pkg;

   // Heading encoding shared with the coordinate datapath
   localparam logic [1:0] DIR_R = 2'b00;
   localparam logic [1:0] DIR_U = 2'b01;
   localparam logic [1:0] DIR_L = 2'b10;
   localparam logic [1:0] DIR_D = 2'b11;

   // PS/2 make codes the game reacts to
   localparam logic [7:0] KEY_START  = 8'h1b;
   localparam logic [7:0] KEY_END    = 8'h76;
   localparam logic [7:0] KEY_PAUSE  = 8'h4d;
   localparam logic [7:0] KEY_RESUME = 8'h2d;
   localparam logic [7:0] KEY_UP     = 8'h75;
   localparam logic [7:0] KEY_DOWN   = 8'h72;
   localparam logic [7:0] KEY_LEFT   = 8'h6b;
   localparam logic [7:0] KEY_RIGHT  = 8'h74;

   // Game states
   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_RUN   = 3'd1;
   localparam logic [2:0] ST_PAUSE = 3'd2;
   localparam logic [2:0] ST_END   = 3'd3;
   localparam logic [2:0] ST_DEAD  = 3'd4;

   // Opposite heading: R<->L and U<->D differ only in the upper bit
   function automatic logic [1:0] reverse(input logic [1:0] d);
      return d ^ 2'b10;
   endfunction

endpackage

// File: rtl/snake_cmd_fifo.sv
// Small direction-command queue: 2-bit entries, QDEPTH deep, with a
// synchronous flush and a view of the most recently pushed (tail) entry.
module snake_cmd_fifo #(
   parameter int unsigned QDEPTH = 4
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic                          flush_i,
   input  logic                          push_i,
   input  logic                          pop_i,
   input  logic [1:0]                    data_i,
   output logic [1:0]                    head_o,
   output logic [1:0]                    tail_o,
   output logic                          full_o,
   output logic                          empty_o,
   output logic [$clog2(QDEPTH+1)-1:0]   count_o
);

   localparam int unsigned AW = $clog2(QDEPTH);
   localparam int unsigned CW = $clog2(QDEPTH + 1);

   logic [1:0]    mem_q [QDEPTH];
   logic [AW-1:0] wr_ptr_q;
   logic [AW-1:0] rd_ptr_q;
   logic [CW-1:0] count_q;
   logic [AW-1:0] tail_idx;
   logic          do_push;
   logic          do_pop;

   assign full_o   = (count_q == CW'(QDEPTH));
   assign empty_o  = (count_q == '0);
   assign count_o  = count_q;
   assign tail_idx = wr_ptr_q - AW'(1);
   assign head_o   = mem_q[rd_ptr_q];
   assign tail_o   = mem_q[tail_idx];
   assign do_push  = push_i && !full_o;
   assign do_pop   = pop_i && !empty_o;

   // Pointer, occupancy and storage update; flush empties without touching storage
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         for (int unsigned i = 0; i < QDEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (flush_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
            wr_ptr_q        <= wr_ptr_q + AW'(1);
         end
         if (do_pop) begin
            rd_ptr_q <= rd_ptr_q + AW'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/snake_move_scheduler.sv
// Snake movement scheduler: decodes PS/2 keys into game-state changes and
// queued turns, and issues the periodic one-cycle step with its heading.
module snake_move_scheduler
   import snake_pkg::*;
#(
   parameter int unsigned SLOW_DIV = 10_000_000,
   parameter int unsigned FAST_DIV = 5_000_000,
   parameter int unsigned QDEPTH   = 4
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic [7:0] scancode,
   input  logic       strobe,
   input  logic       sw8,
   input  logic       hit,
   output logic       step,
   output logic [1:0] dir,
   output logic       restart,
   output logic       paused,
   output logic       over,
   output logic [2:0] qcount
);

   localparam int unsigned DIV_MAX = (SLOW_DIV > FAST_DIV) ? SLOW_DIV : FAST_DIV;
   localparam int unsigned CNT_W   = $clog2(DIV_MAX);
   localparam int unsigned QCW     = $clog2(QDEPTH + 1);

   logic [2:0]       state_q,   state_d;
   logic [CNT_W-1:0] cnt_q,     cnt_d;
   logic             step_q,    step_d;
   logic [1:0]       dir_q,     dir_d;
   logic             restart_q, restart_d;
   logic             paused_q,  paused_d;
   logic             over_q,    over_d;

   logic             key_start, key_end, key_pause, key_resume;
   logic             key_is_dir;
   logic [1:0]       key_dir;
   logic [CNT_W-1:0] div_m1;
   logic             terminal;

   logic             q_push, q_pop;
   logic [1:0]       q_head, q_tail, ref_dir;
   logic             q_full, q_empty;
   logic [QCW-1:0]   q_count;

   snake_cmd_fifo #(
      .QDEPTH (QDEPTH)
   ) u_cmd_fifo (
      .clk_i   (CLK),
      .rst_i   (RST),
      .flush_i (key_start),
      .push_i  (q_push),
      .pop_i   (q_pop),
      .data_i  (key_dir),
      .head_o  (q_head),
      .tail_o  (q_tail),
      .full_o  (q_full),
      .empty_o (q_empty),
      .count_o (q_count)
   );

   assign div_m1   = sw8 ? CNT_W'(FAST_DIV - 1) : CNT_W'(SLOW_DIV - 1);
   assign terminal = (cnt_q >= div_m1);

   // Scancode decode, qualified by strobe
   always_comb begin
      key_start  = 1'b0;
      key_end    = 1'b0;
      key_pause  = 1'b0;
      key_resume = 1'b0;
      key_is_dir = 1'b0;
      key_dir    = DIR_R;
      if (strobe) begin
         case (scancode)
            KEY_START:  key_start  = 1'b1;
            KEY_END:    key_end    = 1'b1;
            KEY_PAUSE:  key_pause  = 1'b1;
            KEY_RESUME: key_resume = 1'b1;
            KEY_UP:     begin key_is_dir = 1'b1; key_dir = DIR_U; end
            KEY_DOWN:   begin key_is_dir = 1'b1; key_dir = DIR_D; end
            KEY_LEFT:   begin key_is_dir = 1'b1; key_dir = DIR_L; end
            KEY_RIGHT:  begin key_is_dir = 1'b1; key_dir = DIR_R; end
            default:    ;
         endcase
      end
   end

   // Game state transitions; start wins everywhere, then end, then death over pause
   always_comb begin
      state_d   = state_q;
      restart_d = 1'b0;
      if (key_start) begin
         state_d   = ST_RUN;
         restart_d = 1'b1;
      end else if (key_end && (state_q inside {ST_RUN, ST_PAUSE, ST_DEAD})) begin
         state_d = ST_END;
      end else begin
         case (state_q)
            ST_RUN: begin
               if (hit && !step_q) begin
                  state_d = ST_DEAD;
               end else if (key_pause) begin
                  state_d = ST_PAUSE;
               end
            end
            ST_PAUSE: begin
               if (key_resume) begin
                  state_d = ST_RUN;
               end
            end
            default: ;
         endcase
      end
      paused_d = (state_d == ST_PAUSE);
      over_d   = (state_d == ST_END) || (state_d == ST_DEAD);
   end

   // Step divider: counts only while staying in RUN, so a pause holds the value it had
   always_comb begin
      cnt_d  = cnt_q;
      step_d = 1'b0;
      if (key_start || (state_d == ST_END) || (state_d == ST_DEAD)) begin
         cnt_d = '0;
      end else if ((state_q == ST_RUN) && (state_d == ST_RUN)) begin
         if (terminal) begin
            cnt_d  = '0;
            step_d = 1'b1;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   // Turn queue control: reference is the pre-pop tail, pop only an already-present head
   always_comb begin
      ref_dir = q_empty ? dir_q : q_tail;
      q_push  = key_is_dir
                && ((state_q == ST_RUN) || (state_q == ST_PAUSE))
                && (key_dir != ref_dir)
                && (key_dir != reverse(ref_dir))
                && !q_full;
      q_pop   = step_d && !q_empty;
      dir_d   = dir_q;
      if (key_start) begin
         dir_d = DIR_R;
      end else if (q_pop) begin
         dir_d = q_head;
      end
   end

   // Registered state and outputs
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         step_q    <= 1'b0;
         dir_q     <= DIR_R;
         restart_q <= 1'b0;
         paused_q  <= 1'b0;
         over_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         step_q    <= step_d;
         dir_q     <= dir_d;
         restart_q <= restart_d;
         paused_q  <= paused_d;
         over_q    <= over_d;
      end
   end

   assign step    = step_q;
   assign dir     = dir_q;
   assign restart = restart_q;
   assign paused  = paused_q;
   assign over    = over_q;
   assign qcount  = 3'(q_count);

endmodule
